// File: rtl/dragon_segment_queue.sv
// dragon_segment_queue: shift-register "dragon" body with grow/shrink and self-collision detection.
// Latency: every accepted command (and revive/reset) updates all registered outputs one clock later.
// Backpressure: cmd_ready is low only in DEAD; unaccepted cycles leave all state untouched.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   cmd_valid/ready command handshake; cmd = 00 MOVE, 01 GROW, 10 SHRINK, 11 NOP
//   head_in         new head {orientation, position}
//   revive          pulse: return to EMPTY from any state (beats a same-cycle command)
//   body            packed slots, slot 0 (head) in the low SEG_W bits
//   length          live segment count
//   tail_seg        copy of slot length-1 (0 when empty)
//   collide         one-cycle pulse, head landed on a body segment
//   overflow        one-cycle pulse, GROW attempted at MAX_SEG
//   dead            high from death until revive or reset
module dragon_segment_queue #(
  parameter  int ORIEN_W         = 2,
  parameter  int POS_W           = 8,
  parameter  int MAX_SEG         = 8,
  parameter  bit KILL_ON_COLLIDE = 1'b1,
  localparam int SEG_W           = ORIEN_W + POS_W,
  localparam int LEN_W           = $clog2(MAX_SEG + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd,
  input  logic [SEG_W-1:0]         head_in,
  input  logic                     revive,
  output logic [SEG_W*MAX_SEG-1:0] body,
  output logic [LEN_W-1:0]         length,
  output logic [SEG_W-1:0]         tail_seg,
  output logic                     collide,
  output logic                     overflow,
  output logic                     dead
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ALIVE = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_MOVE   = 2'b00;
  localparam logic [1:0] CMD_GROW   = 2'b01;
  localparam logic [1:0] CMD_SHRINK = 2'b10;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SEG);

  state_t                          r_state;
  logic [MAX_SEG-1:0][SEG_W-1:0]   r_body;
  logic [LEN_W-1:0]                r_len;
  logic [SEG_W-1:0]                r_tail;
  logic                            r_collide;
  logic                            r_overflow;
  logic                            r_dead;

  state_t                          w_nxt_state;
  logic [MAX_SEG-1:0][SEG_W-1:0]   w_nxt_body;
  logic [LEN_W-1:0]                w_nxt_len;
  logic [SEG_W-1:0]                w_nxt_tail;
  logic                            w_nxt_collide;
  logic                            w_nxt_overflow;
  logic                            w_nxt_dead;

  logic                            w_accept;
  logic [MAX_SEG-1:0][SEG_W-1:0]   w_shift;
  logic [MAX_SEG-1:0][SEG_W-1:0]   w_masked;
  logic [LEN_W-1:0]                w_newlen;
  logic [SEG_W-1:0]                w_newtail;
  logic                            w_hit;

  assign cmd_ready = (r_state != S_DEAD);
  assign w_accept  = cmd_valid & cmd_ready;

  // ALIVE datapath, computed every cycle and only committed when a command is taken.
  always_comb begin
    w_shift   = '0;
    w_masked  = '0;
    w_newlen  = r_len;
    w_newtail = '0;
    w_hit     = 1'b0;

    w_shift[0] = head_in;
    for (int i = 1; i < MAX_SEG; i++) begin
      w_shift[i] = r_body[i-1];
    end

    case (cmd)
      CMD_GROW:   w_newlen = (r_len == LEN_MAX) ? r_len : r_len + 1'b1;
      CMD_SHRINK: w_newlen = (r_len == '0) ? r_len : r_len - 1'b1;
      default:    w_newlen = r_len;
    endcase

    // Slots at or beyond the new length are cleared so the register never holds stale segments.
    for (int i = 0; i < MAX_SEG; i++) begin
      if (LEN_W'(i) < w_newlen) begin
        w_masked[i] = w_shift[i];
      end
      if (LEN_W'(i + 1) == w_newlen) begin
        w_newtail = w_shift[i];
      end
    end

    // Pre-update slot i ends up at index i+1; it only counts if it survives the mask.
    // That excludes the segment vacating the tail on a MOVE. Orientation is ignored.
    for (int i = 0; i < MAX_SEG - 1; i++) begin
      if ((LEN_W'(i + 1) < w_newlen) && (r_body[i][POS_W-1:0] == head_in[POS_W-1:0])) begin
        w_hit = 1'b1;
      end
    end
  end

  // Next-state / next-output process.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_body     = r_body;
    w_nxt_len      = r_len;
    w_nxt_tail     = r_tail;
    w_nxt_collide  = 1'b0;
    w_nxt_overflow = 1'b0;
    w_nxt_dead     = r_dead;

    if (revive) begin
      w_nxt_state = S_EMPTY;
      w_nxt_body  = '0;
      w_nxt_len   = '0;
      w_nxt_tail  = '0;
      w_nxt_dead  = 1'b0;
    end else if (w_accept) begin
      case (r_state)
        S_EMPTY: begin
          if ((cmd == CMD_MOVE) || (cmd == CMD_GROW)) begin
            w_nxt_state   = S_ALIVE;
            w_nxt_body    = '0;
            w_nxt_body[0] = head_in;
            w_nxt_len     = LEN_W'(1);
            w_nxt_tail    = head_in;
          end
        end
        S_ALIVE: begin
          if ((cmd == CMD_MOVE) || (cmd == CMD_GROW) || (cmd == CMD_SHRINK)) begin
            w_nxt_body     = w_masked;
            w_nxt_len      = w_newlen;
            w_nxt_tail     = w_newtail;
            w_nxt_collide  = w_hit;
            w_nxt_overflow = (cmd == CMD_GROW) && (r_len == LEN_MAX);
            if (w_newlen == '0) begin
              w_nxt_state = S_DEAD;
              w_nxt_dead  = 1'b1;
            end else if (w_hit && KILL_ON_COLLIDE) begin
              w_nxt_state = S_DEAD;
              w_nxt_dead  = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_body     <= '0;
      r_len      <= '0;
      r_tail     <= '0;
      r_collide  <= 1'b0;
      r_overflow <= 1'b0;
      r_dead     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_body     <= w_nxt_body;
      r_len      <= w_nxt_len;
      r_tail     <= w_nxt_tail;
      r_collide  <= w_nxt_collide;
      r_overflow <= w_nxt_overflow;
      r_dead     <= w_nxt_dead;
    end
  end

  assign body     = r_body;
  assign length   = r_len;
  assign tail_seg = r_tail;
  assign collide  = r_collide;
  assign overflow = r_overflow;
  assign dead     = r_dead;

endmodule

// File: tb/tb_dragon_segment_queue.sv
// Directed-vector bench for dragon_segment_queue with a scoreboard queue and a decoupled monitor.
// A second instance with KILL_ON_COLLIDE=0 shares the stimulus; its fields are checked on collision steps.
module tb_dragon_segment_queue;

  localparam logic [1:0] MV = 2'b00;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] NP = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [9:0]  head_in;
  logic        revive;

  logic        cmd_ready, nk_ready;
  logic [79:0] body, nk_body;
  logic [3:0]  length, nk_length;
  logic [9:0]  tail_seg, nk_tail;
  logic        collide, nk_collide;
  logic        overflow, nk_overflow;
  logic        dead, nk_dead;

  dragon_segment_queue u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .head_in(head_in), .revive(revive), .body(body), .length(length), .tail_seg(tail_seg),
    .collide(collide), .overflow(overflow), .dead(dead)
  );

  dragon_segment_queue #(.KILL_ON_COLLIDE(1'b0)) u_dut_nk (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(nk_ready), .cmd(cmd),
    .head_in(head_in), .revive(revive), .body(nk_body), .length(nk_length), .tail_seg(nk_tail),
    .collide(nk_collide), .overflow(nk_overflow), .dead(nk_dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [79:0] b;
    logic [3:0]  l;
    logic [9:0]  t;
    logic        c, o, d, r;
    logic        cn;
    logic [3:0]  nl;
    logic        nc, nd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, want);
    end
  endtask

  // Monitor: each record is due the cycle after its stimulus edge; compare all outputs then.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.due != cyc) begin
        errors++;
        $display("FAIL late_record got cycle %0d want %0d", cyc, mon_e.due);
      end
      chk("body",      body,      mon_e.b);
      chk("length",    80'(length),    80'(mon_e.l));
      chk("tail_seg",  80'(tail_seg),  80'(mon_e.t));
      chk("collide",   80'(collide),   80'(mon_e.c));
      chk("overflow",  80'(overflow),  80'(mon_e.o));
      chk("dead",      80'(dead),      80'(mon_e.d));
      chk("cmd_ready", 80'(cmd_ready), 80'(mon_e.r));
      if (mon_e.cn) begin
        chk("nk_length",  80'(nk_length),  80'(mon_e.nl));
        chk("nk_collide", 80'(nk_collide), 80'(mon_e.nc));
        chk("nk_dead",    80'(nk_dead),    80'(mon_e.nd));
      end
    end
  end

  function automatic logic [79:0] mk4(input logic [9:0] s0, s1, s2, s3);
    return {40'h0, s3, s2, s1, s0};
  endfunction

  function automatic logic [79:0] mk8(input logic [9:0] s0, s1, s2, s3, s4, s5, s6, s7);
    return {s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic stepx(input logic rst, rv, v, input logic [1:0] c, input logic [9:0] h,
                       input logic [79:0] eb, input logic [3:0] el, input logic [9:0] et,
                       input logic ec, eo, ed, er,
                       input logic cn, input logic [3:0] nl, input logic nc, nd);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    revive    = rv;
    cmd_valid = v;
    cmd       = c;
    head_in   = h;
    e.due = cyc + 1;
    e.b = eb; e.l = el; e.t = et;
    e.c = ec; e.o = eo; e.d = ed; e.r = er;
    e.cn = cn; e.nl = nl; e.nc = nc; e.nd = nd;
    q.push_back(e);
  endtask

  task automatic step(input logic rst, rv, v, input logic [1:0] c, input logic [9:0] h,
                      input logic [79:0] eb, input logic [3:0] el, input logic [9:0] et,
                      input logic ec, eo, ed, er);
    stepx(rst, rv, v, c, h, eb, el, et, ec, eo, ed, er, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; revive = 1'b0; cmd_valid = 1'b0; cmd = NP; head_in = '0;

    // reset state
    step(0,0,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);
    step(0,0,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);

    // spawn and move
    step(1,0,1,GR,10'h011, mk4(10'h011,0,0,0),1,10'h011, 0,0,0,1);
    step(1,0,1,MV,10'h012, mk4(10'h012,0,0,0),1,10'h012, 0,0,0,1);
    step(1,0,1,MV,10'h013, mk4(10'h013,0,0,0),1,10'h013, 0,0,0,1);
    // NOP and unaccepted cycles change nothing
    step(1,0,1,NP,10'h3FF, mk4(10'h013,0,0,0),1,10'h013, 0,0,0,1);
    step(1,0,0,GR,10'h055, mk4(10'h013,0,0,0),1,10'h013, 0,0,0,1);

    // revive, SHRINK ignored while EMPTY
    step(1,1,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);
    step(1,0,1,SH,10'h077, 80'h0,0,10'h000, 0,0,0,1);

    // grow to saturation
    step(1,0,1,GR,10'h020, mk4(10'h020,0,0,0),1,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h021, mk4(10'h021,10'h020,0,0),2,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h022, mk4(10'h022,10'h021,10'h020,0),3,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h023, mk4(10'h023,10'h022,10'h021,10'h020),4,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h024, mk8(10'h024,10'h023,10'h022,10'h021,10'h020,0,0,0),5,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h025, mk8(10'h025,10'h024,10'h023,10'h022,10'h021,10'h020,0,0),6,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h026, mk8(10'h026,10'h025,10'h024,10'h023,10'h022,10'h021,10'h020,0),7,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h027, mk8(10'h027,10'h026,10'h025,10'h024,10'h023,10'h022,10'h021,10'h020),8,10'h020, 0,0,0,1);
    step(1,0,1,GR,10'h028, mk8(10'h028,10'h027,10'h026,10'h025,10'h024,10'h023,10'h022,10'h021),8,10'h021, 0,1,0,1);
    step(1,0,1,NP,10'h000, mk8(10'h028,10'h027,10'h026,10'h025,10'h024,10'h023,10'h022,10'h021),8,10'h021, 0,0,0,1);

    // shrink to death, commands refused, revive
    step(1,1,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);
    step(1,0,1,MV,10'h030, mk4(10'h030,0,0,0),1,10'h030, 0,0,0,1);
    step(1,0,1,GR,10'h031, mk4(10'h031,10'h030,0,0),2,10'h030, 0,0,0,1);
    step(1,0,1,SH,10'h032, mk4(10'h032,0,0,0),1,10'h032, 0,0,0,1);
    step(1,0,1,SH,10'h033, 80'h0,0,10'h000, 0,0,1,0);
    step(1,0,1,GR,10'h034, 80'h0,0,10'h000, 0,0,1,0);
    step(1,1,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);

    // self-collision (head orientation differs from the hit segment)
    step(1,0,1,GR,10'h010, mk4(10'h010,0,0,0),1,10'h010, 0,0,0,1);
    step(1,0,1,GR,10'h011, mk4(10'h011,10'h010,0,0),2,10'h010, 0,0,0,1);
    step(1,0,1,GR,10'h012, mk4(10'h012,10'h011,10'h010,0),3,10'h010, 0,0,0,1);
    step(1,0,1,GR,10'h013, mk4(10'h013,10'h012,10'h011,10'h010),4,10'h010, 0,0,0,1);
    stepx(1,0,1,MV,10'h211, mk4(10'h211,10'h013,10'h012,10'h011),4,10'h011, 1,0,1,0, 1,4,1,0);
    stepx(1,0,1,NP,10'h000, mk4(10'h211,10'h013,10'h012,10'h011),4,10'h011, 0,0,1,0, 1,4,0,0);
    stepx(1,1,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1, 1,0,0,0);

    // tail slot vacates on MOVE: no collision; on GROW it stays: collision
    step(1,0,1,GR,10'h040, mk4(10'h040,0,0,0),1,10'h040, 0,0,0,1);
    step(1,0,1,GR,10'h041, mk4(10'h041,10'h040,0,0),2,10'h040, 0,0,0,1);
    step(1,0,1,GR,10'h042, mk4(10'h042,10'h041,10'h040,0),3,10'h040, 0,0,0,1);
    step(1,0,1,MV,10'h040, mk4(10'h040,10'h042,10'h041,0),3,10'h041, 0,0,0,1);
    stepx(1,0,1,GR,10'h041, mk4(10'h041,10'h040,10'h042,10'h041),4,10'h041, 1,0,1,0, 1,4,1,0);

    // revive beats a simultaneous GROW
    stepx(1,1,1,GR,10'h050, 80'h0,0,10'h000, 0,0,0,1, 1,0,0,0);

    // reset during ALIVE length 5 overrides revive and command
    step(1,0,1,GR,10'h060, mk4(10'h060,0,0,0),1,10'h060, 0,0,0,1);
    step(1,0,1,GR,10'h061, mk4(10'h061,10'h060,0,0),2,10'h060, 0,0,0,1);
    step(1,0,1,GR,10'h062, mk4(10'h062,10'h061,10'h060,0),3,10'h060, 0,0,0,1);
    step(1,0,1,GR,10'h063, mk4(10'h063,10'h062,10'h061,10'h060),4,10'h060, 0,0,0,1);
    step(1,0,1,GR,10'h064, mk8(10'h064,10'h063,10'h062,10'h061,10'h060,0,0,0),5,10'h060, 0,0,0,1);
    step(0,1,1,GR,10'h065, 80'h0,0,10'h000, 0,0,0,1);

    // back in EMPTY after reset; then reset out of DEAD
    step(1,0,1,GR,10'h070, mk4(10'h070,0,0,0),1,10'h070, 0,0,0,1);
    step(1,0,1,SH,10'h071, 80'h0,0,10'h000, 0,0,1,0);
    step(0,0,1,GR,10'h072, 80'h0,0,10'h000, 0,0,0,1);
    step(1,0,0,NP,10'h000, 80'h0,0,10'h000, 0,0,0,1);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
